// File: rtl/integration_file_arbiter_if.sv
// Avalon-MM write bus from the arbiter to one integration_file instance,
// including its synchronous clear line.
interface integration_file_arbiter_if #(
   parameter int N  = 32,
   parameter int AW = 8
);
   logic [AW-1:0] avm_address;
   logic          avm_write;
   logic [N-1:0]  avm_writedata;
   logic          avm_srst;

   modport master (
      output avm_address,
      output avm_write,
      output avm_writedata,
      output avm_srst
   );

   modport slave (
      input avm_address,
      input avm_write,
      input avm_writedata,
      input avm_srst
   );
endinterface

// File: rtl/integration_file_arbiter.sv
// Two-requester write arbiter for integration_file: per-requester FIFOs drained
// round-robin as single-cycle Avalon writes, with a prioritised multi-cycle clear.
module integration_file_arbiter_fifo #(
   parameter int W     = 40,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         ready,
   output logic         nonempty,
   output logic [W-1:0] head
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push_ok;

   // A full FIFO refuses a push even if it pops in the same cycle.
   assign ready    = (count != CW'(DEPTH));
   assign nonempty = (count != '0);
   assign push_ok  = push && ready;
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push_ok) - CW'(pop);
      end
   end
endmodule

module integration_file_arbiter #(
   parameter int N          = 32,
   parameter int AW         = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CLR_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        arst_n,
   input  logic                        req0_valid,
   output logic                        req0_ready,
   input  logic [AW-1:0]               req0_address,
   input  logic [N-1:0]                req0_data,
   input  logic                        req1_valid,
   output logic                        req1_ready,
   input  logic [AW-1:0]               req1_address,
   input  logic [N-1:0]                req1_data,
   input  logic                        clr_req,
   integration_file_arbiter_if.master  avm,
   output logic                        grant_id,
   output logic                        busy,
   output logic [1:0]                  state_dbg
);
   // Handshake: a requester entry transfers on a rising edge where valid && ready;
   // ready depends only on that requester's FIFO fill level.
   localparam int EW = AW + N;
   localparam int KW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, CLEAR = 2'd2} state_t;

   state_t        state, next_state;
   logic          ne0, ne1, pop0, pop1, grant, last_grant;
   logic [EW-1:0] head0, head1;
   logic [KW-1:0] clr_cnt;
   logic [AW-1:0] addr_q;
   logic [N-1:0]  data_q;
   logic          write_q, srst_q;

   integration_file_arbiter_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
      .clk(clk), .arst_n(arst_n), .push(req0_valid), .push_data({req0_address, req0_data}),
      .pop(pop0), .ready(req0_ready), .nonempty(ne0), .head(head0)
   );

   integration_file_arbiter_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
      .clk(clk), .arst_n(arst_n), .push(req1_valid), .push_data({req1_address, req1_data}),
      .pop(pop1), .ready(req1_ready), .nonempty(ne1), .head(head1)
   );

   always_comb begin
      next_state = state;
      grant      = last_grant;
      pop0       = 1'b0;
      pop1       = 1'b0;
      case (state)
         CLEAR: begin
            // Counter is not restarted by clr_req arriving mid-clear.
            if (clr_cnt == KW'(CLR_CYCLES - 1)) next_state = IDLE;
         end
         default: begin
            if (clr_req) begin
               next_state = CLEAR;
            end else if (ne0 || ne1) begin
               grant      = (ne0 && ne1) ? ~last_grant : ne1;
               pop0       = ~grant;
               pop1       = grant;
               next_state = WRITE;
            end else begin
               next_state = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state      <= IDLE;
         clr_cnt    <= '0;
         last_grant <= 1'b1;
         write_q    <= 1'b0;
         srst_q     <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         grant_id   <= 1'b0;
      end else begin
         state   <= next_state;
         clr_cnt <= (state == CLEAR) ? clr_cnt + KW'(1) : '0;
         srst_q  <= (next_state == CLEAR);
         write_q <= pop0 | pop1;
         if (pop0 | pop1) begin
            {addr_q, data_q} <= grant ? head1 : head0;
            grant_id         <= grant;
            last_grant       <= grant;
         end
      end
   end

   assign avm.avm_address   = addr_q;
   assign avm.avm_write     = write_q;
   assign avm.avm_writedata = data_q;
   assign avm.avm_srst      = srst_q;
   assign busy              = (state == CLEAR) | ne0 | ne1 | write_q;
   assign state_dbg         = state;
endmodule

// File: tb/tb_integration_file_arbiter.sv
// Bench for integration_file_arbiter: queue-based reference model checked every
// cycle, plus literal expectations on the write sequences of each scenario.
module tb_integration_file_arbiter;
   localparam int N          = 32;
   localparam int AW         = 8;
   localparam int DEPTH      = 4;
   localparam int CLR_CYCLES = 2;

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0, clr_req = 1'b0;
   logic [AW-1:0] req0_address = '0, req1_address = '0;
   logic [N-1:0]  req0_data = '0, req1_data = '0;
   logic          req0_ready, req1_ready, grant_id, busy;
   logic [1:0]    state_dbg;

   integration_file_arbiter_if #(.N(N), .AW(AW)) avm ();

   integration_file_arbiter #(.N(N), .AW(AW), .FIFO_DEPTH(DEPTH), .CLR_CYCLES(CLR_CYCLES)) dut (
      .clk(clk), .arst_n(arst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_address(req0_address), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_address(req1_address), .req1_data(req1_data),
      .clr_req(clr_req), .avm(avm), .grant_id(grant_id), .busy(busy), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model: per-requester queues, clear countdown, round-robin pointer
   logic [AW+N-1:0] exp_q0[$], exp_q1[$];
   int              clr_left;
   logic            last_g, exp_write, exp_srst, exp_grant;
   logic [AW-1:0]   exp_addr;
   logic [N-1:0]    exp_data;

   task automatic model_step();
      logic acc0, acc1, g;
      logic [AW+N-1:0] item;
      if (!arst_n) begin
         exp_q0.delete(); exp_q1.delete();
         clr_left = 0; last_g = 1'b1;
         exp_write = 0; exp_srst = 0; exp_grant = 0; exp_addr = '0; exp_data = '0;
      end else begin
         acc0 = req0_valid && (exp_q0.size() < DEPTH);
         acc1 = req1_valid && (exp_q1.size() < DEPTH);
         exp_write = 1'b0;
         if (clr_left > 0) begin
            clr_left--;
            exp_srst = (clr_left > 0);
         end else if (clr_req) begin
            clr_left = CLR_CYCLES;
            exp_srst = 1'b1;
         end else begin
            exp_srst = 1'b0;
            if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
               g = (exp_q0.size() > 0 && exp_q1.size() > 0) ? !last_g : (exp_q1.size() > 0);
               item = g ? exp_q1.pop_front() : exp_q0.pop_front();
               {exp_addr, exp_data} = item;
               exp_write = 1'b1;
               exp_grant = g;
               last_g = g;
            end
         end
         if (acc0) exp_q0.push_back({req0_address, req0_data});
         if (acc1) exp_q1.push_back({req1_address, req1_data});
      end
   endtask

   // observed write log for the literal checks
   logic [N-1:0]  log_data[$];
   logic [AW-1:0] log_addr[$];
   logic          log_grant[$];
   int            log_cyc[$];
   int            srst_cycles;

   task automatic clear_logs();
      log_data.delete(); log_addr.delete(); log_grant.delete(); log_cyc.delete();
      srst_cycles = 0;
   endtask

   // scoreboard compare, once per cycle just after the edge
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         cyc++;
         check("avm_write", avm.avm_write, exp_write);
         check("avm_srst", avm.avm_srst, exp_srst);
         check("grant_id", grant_id, exp_grant);
         check("avm_address", avm.avm_address, exp_addr);
         check("avm_writedata", avm.avm_writedata, exp_data);
         check("req0_ready", req0_ready, exp_q0.size() < DEPTH);
         check("req1_ready", req1_ready, exp_q1.size() < DEPTH);
         check("busy", busy, (clr_left > 0) || exp_q0.size() > 0 || exp_q1.size() > 0 || exp_write);
         if (avm.avm_write) begin
            log_data.push_back(avm.avm_writedata);
            log_addr.push_back(avm.avm_address);
            log_grant.push_back(grant_id);
            log_cyc.push_back(cyc);
         end
         if (avm.avm_srst) srst_cycles++;
      end
   end

   // driver
   logic [AW-1:0] st_addr[2][16];
   logic [N-1:0]  st_data[2][16];

   task automatic push_stream(input int rid, input int n);
      int i = 0;
      int guard = 0;
      logic acc;
      while (i < n && guard < 200) begin
         @(negedge clk);
         if (rid == 0) begin
            req0_valid = 1'b1; req0_address = st_addr[0][i]; req0_data = st_data[0][i]; acc = req0_ready;
         end else begin
            req1_valid = 1'b1; req1_address = st_addr[1][i]; req1_data = st_data[1][i]; acc = req1_ready;
         end
         @(posedge clk);
         if (acc) i++;
         guard++;
      end
      @(negedge clk);
      if (rid == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      check("stream_accepted", i, n);
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst_n = 1'b0;
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
   endtask

   int   exp_a[8], exp_d[8], exp_g[8];

   task automatic check_writes(input string name, input int n, input bit consec);
      check({name, "_count"}, log_data.size(), n);
      for (int k = 0; k < n && k < log_data.size(); k++) begin
         check({name, "_addr"}, log_addr[k], exp_a[k]);
         check({name, "_data"}, log_data[k], exp_d[k]);
         check({name, "_grant"}, log_grant[k], exp_g[k]);
         if (consec && k > 0) check({name, "_gap"}, log_cyc[k] - log_cyc[k-1], 1);
      end
   endtask

   // directed scenarios
   initial begin
      bit seen;
      #12;
      check("rst_write", avm.avm_write, 0);
      check("rst_srst", avm.avm_srst, 0);
      check("rst_grant", grant_id, 0);
      check("rst_busy", busy, 0);
      check("rst_ready0", req0_ready, 1);
      check("rst_ready1", req1_ready, 1);
      @(negedge clk);
      arst_n = 1'b1;

      // two back-to-back pushes on requester 0
      clear_logs();
      st_addr[0][0] = 8'd0; st_data[0][0] = 32'd55;
      st_addr[0][1] = 8'd1; st_data[0][1] = 32'd22;
      push_stream(0, 2);
      repeat (6) @(negedge clk);
      exp_a = '{0, 1, 0, 0, 0, 0, 0, 0};
      exp_d = '{55, 22, 0, 0, 0, 0, 0, 0};
      exp_g = '{0, 0, 0, 0, 0, 0, 0, 0};
      check_writes("t1", 2, 1'b1);

      // both requesters push in lockstep, grants alternate
      do_reset();
      clear_logs();
      for (int k = 0; k < 3; k++) begin
         st_addr[0][k] = AW'(1 + k);  st_data[0][k] = N'(1 + k);
         st_addr[1][k] = AW'(11 + k); st_data[1][k] = N'(11 + k);
      end
      fork
         push_stream(0, 3);
         push_stream(1, 3);
      join
      repeat (10) @(negedge clk);
      exp_a = '{1, 11, 2, 12, 3, 13, 0, 0};
      exp_d = '{1, 11, 2, 12, 3, 13, 0, 0};
      exp_g = '{0, 1, 0, 1, 0, 1, 0, 0};
      check_writes("t2", 6, 1'b1);

      // requester 1 overfills while clear is held
      clear_logs();
      for (int k = 0; k < 5; k++) begin
         st_addr[1][k] = AW'(8'h21 + k); st_data[1][k] = N'(1000 + k);
      end
      @(negedge clk);
      clr_req = 1'b1;
      fork
         push_stream(1, 5);
         begin repeat (5) @(negedge clk); check("t3_ready_full", req1_ready, 0); end
         begin repeat (8) @(negedge clk); clr_req = 1'b0; end
      join
      repeat (12) @(negedge clk);
      exp_a = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 0, 0, 0};
      exp_d = '{1000, 1001, 1002, 1003, 1004, 0, 0, 0};
      exp_g = '{1, 1, 1, 1, 1, 0, 0, 0};
      check_writes("t3", 5, 1'b0);

      // clear pulse beats a pending pop; repeat pulse mid-clear is ignored
      clear_logs();
      st_addr[0][0] = 8'h41; st_data[0][0] = 32'hA1;
      st_addr[0][1] = 8'h42; st_data[0][1] = 32'hA2;
      fork
         push_stream(0, 2);
         begin
            @(negedge clk);
            @(negedge clk); clr_req = 1'b1;
            @(negedge clk);
            @(negedge clk); clr_req = 1'b0;
         end
      join
      repeat (8) @(negedge clk);
      check("t4_srst_cycles", srst_cycles, CLR_CYCLES);
      exp_a = '{8'h41, 8'h42, 0, 0, 0, 0, 0, 0};
      exp_d = '{32'hA1, 32'hA2, 0, 0, 0, 0, 0, 0};
      exp_g = '{0, 0, 0, 0, 0, 0, 0, 0};
      check_writes("t4", 2, 1'b1);

      // asynchronous reset while a requester-1 write is on the bus
      clear_logs();
      for (int k = 0; k < 4; k++) begin
         st_addr[1][k] = AW'(8'h51 + k); st_data[1][k] = N'(32'h5000 + k);
      end
      @(negedge clk);
      clr_req = 1'b1;
      push_stream(1, 4);
      clr_req = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clk);
         #2;
         seen = avm.avm_write;
      end
      check("t5_write_seen", seen, 1);
      check("t5_grant_before", grant_id, 1);
      #1;
      arst_n = 1'b0;
      #1;
      check("t5_async_write", avm.avm_write, 0);
      check("t5_async_srst", avm.avm_srst, 0);
      check("t5_async_grant", grant_id, 0);
      check("t5_async_busy", busy, 0);
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      clear_logs();
      repeat (8) @(negedge clk);
      check("t5_writes_after", log_data.size(), 0);
      check("t5_ready0", req0_ready, 1);
      check("t5_ready1", req1_ready, 1);

      // long single-requester stream, one write per cycle
      clear_logs();
      for (int k = 0; k < 8; k++) begin
         st_addr[0][k] = AW'(k); st_data[0][k] = N'(100 + k);
      end
      push_stream(0, 8);
      repeat (6) @(negedge clk);
      exp_a = '{0, 1, 2, 3, 4, 5, 6, 7};
      exp_d = '{100, 101, 102, 103, 104, 105, 106, 107};
      exp_g = '{0, 0, 0, 0, 0, 0, 0, 0};
      check_writes("t6", 8, 1'b1);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
